dmem_arbiter: RTL and testbench

- Shares the single data_memory port between two requesters: the processor load/store path (port P) and a block-transfer engine (port D) that loads and unloads the vector/text buffer.
- Registered owner FSM with round-robin priority and a burst cap, so neither requester starves.
- Sits between processor/DMA and data_memory; drives the memory's write enable, address and write data.
- data_memory is asynchronous-read and synchronous-write.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_memory port between the processor
// load/store path (port P) and the block-transfer engine (port D).
// A registered owner FSM grants the port with round-robin tie breaking and
// a burst cap so that neither requester can starve the other.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_ack,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_last,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_P = 2'b01,
    OWN_D = 2'b10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_owner;
  logic [CW-1:0] beat_cnt;
  logic          at_cap;

  // Acks only while out of reset, so a reset mid-burst can never write memory.
  assign p_ack   = rst & (state == OWN_P) & p_req;
  assign d_ack   = rst & (state == OWN_D) & d_req;
  assign p_stall = p_req & ~p_ack;
  assign at_cap  = (beat_cnt == BEAT_LAST);

  assign m_we    = (p_ack & p_we) | (d_ack & d_we);
  assign p_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign owner   = state;

  // Route the owning port's address and write data to memory; idle drives zero.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    case (state)
      OWN_P: begin
        m_addr  = p_addr;
        m_wdata = p_wdata;
      end
      OWN_D: begin
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      default: begin
        m_addr  = '0;
        m_wdata = '0;
      end
    endcase
  end

  // Next owner: round-robin on ties, direct handover, burst cap when the other side waits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (p_req && d_req) begin
          state_nxt = last_owner ? OWN_P : OWN_D;
        end else if (p_req) begin
          state_nxt = OWN_P;
        end else if (d_req) begin
          state_nxt = OWN_D;
        end
      end
      OWN_P: begin
        if (!p_req) begin
          state_nxt = d_req ? OWN_D : IDLE;
        end else if (p_ack && at_cap && d_req) begin
          state_nxt = OWN_D;
        end
      end
      OWN_D: begin
        if (d_ack && d_last) begin
          state_nxt = p_req ? OWN_P : IDLE;
        end else if (!d_req) begin
          state_nxt = p_req ? OWN_P : IDLE;
        end else if (d_ack && at_cap && p_req) begin
          state_nxt = OWN_P;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner state, departing-owner memory (1 = engine) and saturating beat counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        beat_cnt <= '0;
        if (state != IDLE) begin
          last_owner <= (state == OWN_D);
        end
      end else if ((p_ack || d_ack) && !at_cap) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a small
// asynchronous-read / synchronous-write memory model behind it.
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int PP   = 0;
  localparam int PD   = 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we, p_ack, p_stall;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          d_req, d_we, d_last, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    owner;

  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  xfer_t pQ[$];
  xfer_t dQ[$];
  int    ackLog[$];
  int    expLog[$];
  int    dAckCount = 0;
  int    total = 0;
  int    bad = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ack(p_ack), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_last(d_last), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .owner(owner)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory model: asynchronous read, synchronous write.
  assign m_rdata = mem[m_addr[7:0]];
  always @(posedge clk) begin
    if (m_we) mem[m_addr[7:0]] <= m_wdata;
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic last);
    xfer_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    if (port == PP) begin
      p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = data;
      pQ.push_back(e);
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = data; d_last = last;
      dQ.push_back(e);
    end
  endtask

  task automatic waitAck(input int port, output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if ((port == PP && p_ack) || (port == PD && d_ack)) return;
    end
    checkOutput("ack_timeout", 64'(lat), 64'(0));
  endtask

  task automatic dropRequest(input int port);
    @(posedge clk); #1;
    if (port == PP) p_req = 1'b0;
    else begin
      d_req = 1'b0;
      d_last = 1'b0;
    end
  endtask

  task automatic doXfer(input int port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic last, output int lat);
    @(posedge clk); #1;
    applyStimulus(port, we, addr, data, last);
    waitAck(port, lat);
    dropRequest(port);
  endtask

  task automatic dBurst(input int n, input logic [AW-1:0] base);
    int lat;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      applyStimulus(PD, 1'b1, base + AW'(i), 32'hE000_0000 | (base + AW'(i)), (i == n - 1));
      waitAck(PD, lat);
    end
    dropRequest(PD);
  endtask

  task automatic waitDAcks(input int target);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (dAckCount >= target) return;
    end
    checkOutput("dcount_timeout", 64'(dAckCount), 64'(target));
  endtask

  task automatic checkOrder(input string tag);
    checkOutput({tag, "_len"}, 64'(ackLog.size()), 64'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < ackLog.size(); i++) begin
      checkOutput($sformatf("%s_%0d", tag, i), 64'(ackLog[i]), 64'(expLog[i]));
    end
  endtask

  task automatic scorePop(input int port);
    xfer_t e;
    string pre;
    logic [7:0] idx;
    pre = (port == PP) ? "p" : "d";
    if (port == PP) begin
      checkOutput("p_q_nonempty", 64'(pQ.size() != 0), 64'(1));
      if (pQ.size() == 0) return;
      e = pQ.pop_front();
    end else begin
      checkOutput("d_q_nonempty", 64'(dQ.size() != 0), 64'(1));
      if (dQ.size() == 0) return;
      e = dQ.pop_front();
      dAckCount++;
    end
    ackLog.push_back(port);
    idx = e.addr[7:0];
    checkOutput({pre, "_maddr"}, 64'(m_addr), 64'(e.addr));
    checkOutput({pre, "_mwe"}, 64'(m_we), 64'(e.we));
    if (e.we) begin
      checkOutput({pre, "_mwdata"}, 64'(m_wdata), 64'(e.data));
      shadow[idx] = e.data;
    end else begin
      checkOutput({pre, "_rdata"}, 64'((port == PP) ? p_rdata : d_rdata), 64'(shadow[idx]));
    end
  endtask

  // Per-cycle monitor: single ack, stall definition, reset gating, scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("one_ack", 64'(p_ack & d_ack), 64'(0));
      checkOutput("p_stall", 64'(p_stall), 64'(p_req & ~p_ack));
      if (!rst) begin
        checkOutput("rst_acks", 64'({p_ack, d_ack}), 64'(0));
      end
      if (p_ack) scorePop(PP);
      else if (d_ack) scorePop(PD);
      else checkOutput("idle_mwe", 64'(m_we), 64'(0));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    int latP, latD, d0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    rst = 1'b0;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_last = 1'b0;

    // Reset held with both ports requesting writes.
    applyStimulus(PP, 1'b1, 32'h10, 32'h1111_1111, 1'b0);
    applyStimulus(PD, 1'b1, 32'h11, 32'h2222_2222, 1'b1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_owner", 64'(owner), 64'(0));
      checkOutput("rst_mwe", 64'(m_we), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("arb_owner", 64'(owner), 64'(0));
    checkOutput("arb_pack", 64'(p_ack), 64'(0));
    @(negedge clk);
    checkOutput("post_rst_owner", 64'(owner), 64'(1));
    checkOutput("post_rst_pack", 64'(p_ack), 64'(1));
    dropRequest(PP);
    waitAck(PD, latD);
    dropRequest(PD);
    #1;
    expLog = '{PP, PD};
    checkOrder("tie_after_rst");
    ackLog.delete();

    // Single processor write from idle, then back-to-back read.
    @(posedge clk); #1;
    applyStimulus(PP, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checkOutput("wr_arb_stall", 64'(p_stall), 64'(1));
    checkOutput("wr_arb_ack", 64'(p_ack), 64'(0));
    @(negedge clk);
    checkOutput("wr_ack", 64'(p_ack), 64'(1));
    checkOutput("wr_mwe", 64'(m_we), 64'(1));
    checkOutput("wr_maddr", 64'(m_addr), 64'(32'h40));
    checkOutput("wr_stall", 64'(p_stall), 64'(0));
    @(posedge clk); #1;
    applyStimulus(PP, 1'b0, 32'h40, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rd_ack", 64'(p_ack), 64'(1));
    checkOutput("rd_data", 64'(p_rdata), 64'(32'hDEAD_BEEF));
    checkOutput("rd_stall", 64'(p_stall), 64'(0));
    dropRequest(PP);
    ackLog.delete();

    // Tie after the processor was last owner: engine wins.
    fork
      doXfer(PP, 1'b1, 32'h50, 32'h5050_5050, 1'b0, latP);
      doXfer(PD, 1'b1, 32'h51, 32'h5151_5151, 1'b1, latD);
    join
    #1;
    expLog = '{PD, PP};
    checkOrder("tie_rr");
    checkOutput("tie_d_lat", 64'(latD), 64'(2));
    ackLog.delete();

    // Burst cap: 10-beat engine write burst, processor read arrives mid-burst.
    d0 = dAckCount;
    fork
      dBurst(10, 32'h0);
      begin
        waitDAcks(d0 + 2);
        doXfer(PP, 1'b0, 32'h2, 32'h0, 1'b0, latP);
      end
    join
    #1;
    expLog = '{PD, PD, PD, PD, PP, PD, PD, PD, PD, PD, PD};
    checkOrder("cap");
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("cap_mem_%0d", i), 64'(mem[i]), 64'(32'hE000_0000 | i));
    end
    ackLog.delete();

    // d_last with nobody waiting: port goes idle.
    dBurst(3, 32'h30);
    @(negedge clk);
    checkOutput("last_idle_owner", 64'(owner), 64'(0));

    // d_last with processor pending: direct handover, no idle gap.
    d0 = dAckCount;
    fork
      dBurst(3, 32'h34);
      begin
        waitDAcks(d0 + 1);
        @(posedge clk); #1;
        applyStimulus(PP, 1'b0, 32'h30, 32'h0, 1'b0);
        waitAck(PP, latP);
        checkOutput("last_handover_owner", 64'(owner), 64'(1));
        checkOutput("last_handover_lat", 64'(latP), 64'(3));
        dropRequest(PP);
      end
    join
    ackLog.delete();

    // Reset during engine beat 2 with processor also requesting.
    d0 = dAckCount;
    fork
      dBurst(5, 32'h20);
      begin
        waitDAcks(d0 + 2);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(PP, 1'b0, 32'h20, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_mwe", 64'(m_we), 64'(0));
        checkOutput("midrst_dack", 64'(d_ack), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_owner", 64'(owner), 64'(0));
        checkOutput("midrst_beat", 64'(dut.beat_cnt), 64'(0));
        @(negedge clk);
        checkOutput("midrst_p_first", 64'(owner), 64'(1));
        checkOutput("midrst_pack", 64'(p_ack), 64'(1));
        checkOutput("midrst_rdata", 64'(p_rdata), 64'(32'hE000_0020));
        dropRequest(PP);
      end
    join
    #1;
    expLog = '{PD, PD, PP, PD, PD, PD};
    checkOrder("midrst");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("midrst_mem_%0d", i), 64'(mem[32'h20 + i]), 64'(32'hE000_0020 + i));
    end

    repeat (2) @(negedge clk);
    checkOutput("pq_empty", 64'(pQ.size()), 64'(0));
    checkOutput("dq_empty", 64'(dQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
